// File: rtl/entity_chain_mover.sv
// entity_chain_mover: moves the cowboy and a chain of up to MAX_PUSH boxes one cell, writing animation phases then final cell types.
// Optional per-frame animation is enabled by defining MOVER_ANIM_EN; without it LOAD goes straight to COMMIT.
module entity_chain_mover #(
  parameter int COLS      = 10,
  parameter int ROWS      = 10,
  parameter int ADDR_W    = 7,
  parameter int MAX_PUSH  = 2,
  parameter int PHASE_MAX = 47
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [1:0]                         dir,
  input  logic [6:0]                         player_row,
  input  logic [6:0]                         player_col,
  input  logic                               player_on_target,
  input  logic [$clog2(MAX_PUSH+1)-1:0]      n_boxes,
  input  logic [MAX_PUSH:0]                  dest_target,
  input  logic                               frame_tick,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic [10:0]                        wr_data,
  output logic                               wr_en,
  output logic [6:0]                         player_row_out,
  output logic [6:0]                         player_col_out,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);
  localparam int NB_W = $clog2(MAX_PUSH+1);
  localparam int IW   = $clog2(MAX_PUSH+2);
  typedef enum logic [2:0] {IDLE, LOAD, ANIM, WAIT, COMMIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [5:0]        phase_q, phase_d;
  logic              pend_q, pend_d;
  logic              err_q;
  logic [6:0]        r_q, c_q, prow_q, pcol_q;
  logic [1:0]        dir_q;
  logic [NB_W-1:0]   nb_q;
  logic [MAX_PUSH:0] dt_q;
  logic              pot_q;
  logic [7:0]        span, dst_r, dst_c;
  logic              accept;
  logic [6:0]        idx7, cur_r, cur_c, c1_r, c1_c;
  logic [MAX_PUSH+1:0] tgt;
  logic              cur_tgt;
  logic [2:0]        anim_t, cmt_t;
  // Request validation: chain length in range and the last destination inside the grid (8-bit math turns underflow into an out-of-range value)
  always_comb begin
    span   = 8'(n_boxes) + 8'd1;
    dst_r  = !dir[1] ? {1'b0, player_row} : dir[0] ? {1'b0, player_row} + span : {1'b0, player_row} - span;
    dst_c  = dir[1] ? {1'b0, player_col} : dir[0] ? {1'b0, player_col} + span : {1'b0, player_col} - span;
    accept = start && (32'(n_boxes) <= MAX_PUSH) && (32'(dst_r) < ROWS) && (32'(dst_c) < COLS);
  end
  // Geometry and cell types of the cell selected by idx; tgt[i] is the target flag of cell ci
  always_comb begin
    idx7    = 7'(idx_q);
    cur_r   = !dir_q[1] ? r_q : dir_q[0] ? r_q + idx7 : r_q - idx7;
    cur_c   = dir_q[1] ? c_q : dir_q[0] ? c_q + idx7 : c_q - idx7;
    c1_r    = !dir_q[1] ? r_q : dir_q[0] ? r_q + 7'd1 : r_q - 7'd1;
    c1_c    = dir_q[1] ? c_q : dir_q[0] ? c_q + 7'd1 : c_q - 7'd1;
    tgt     = {dt_q, pot_q};
    cur_tgt = tgt[idx_q];
    anim_t  = idx_q == '0 ? (cur_tgt ? 3'd7 : 3'd4) : (cur_tgt ? 3'd6 : 3'd5);
    cmt_t   = idx_q >= IW'(2) ? (cur_tgt ? 3'd6 : 3'd5) : idx_q == IW'(1) ? (cur_tgt ? 3'd7 : 3'd4) : {2'b00, cur_tgt};
  end
  // State register plus latched move parameters, error pulse and committed player position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      dir_q   <= '0;
      nb_q    <= '0;
      dt_q    <= '0;
      pot_q   <= 1'b0;
      prow_q  <= '0;
      pcol_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      err_q   <= state_q == IDLE && start && !accept;
      if (state_q == IDLE && accept) begin
        r_q   <= player_row;
        c_q   <= player_col;
        dir_q <= dir;
        nb_q  <= n_boxes;
        dt_q  <= dest_target;
        pot_q <= player_on_target;
      end
      if (state_q == COMMIT && idx_q == '0) begin
        prow_q <= c1_r;
        pcol_q <= c1_c;
      end
    end
  end
  // Next-state: ANIM walks c0..cn, WAIT consumes a live or pending frame tick, COMMIT walks c(n+1) down to c0
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        phase_d = '0;
        pend_d  = 1'b0;
`ifdef MOVER_ANIM_EN
        state_d = ANIM;
        idx_d   = '0;
`else
        state_d = COMMIT;
        idx_d   = IW'(nb_q) + 1'b1;
`endif
      end
      ANIM: begin
        pend_d = pend_q | frame_tick;
        if (idx_q == IW'(nb_q)) state_d = WAIT;
        else idx_d = idx_q + 1'b1;
      end
      WAIT: if (frame_tick || pend_q) begin
        pend_d = 1'b0;
        if (32'(phase_q) < PHASE_MAX) begin
          phase_d = phase_q + 1'b1;
          idx_d   = '0;
          state_d = ANIM;
        end else begin
          idx_d   = IW'(nb_q) + 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT: if (idx_q == '0) state_d = DONE;
              else idx_d = idx_q - 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decoded from state; write bus held at zero outside write states
  always_comb begin
    wr_en          = state_q == ANIM || state_q == COMMIT;
    wr_addr        = wr_en ? ADDR_W'(32'(cur_r) * COLS + 32'(cur_c)) : '0;
    wr_data        = state_q == ANIM ? {anim_t, phase_q, dir_q} : state_q == COMMIT ? {cmt_t, 8'd0} : '0;
    busy           = state_q == LOAD || state_q == ANIM || state_q == WAIT || state_q == COMMIT;
    done           = state_q == DONE;
    err            = err_q;
    player_row_out = prow_q;
    player_col_out = pcol_q;
  end
endmodule

// File: doc/entity_chain_mover.md
Name: entity_chain_mover

Overview:
- Parametrised successor of the single cowboy/box mover.
- Moves the cowboy plus a chain of 0..MAX_PUSH pushed boxes one cell in a given direction.
- Writes per-frame animation-phase words into the object map through a single write port, then commits the final cell types.
- Sits between the move-validation logic (which supplies the chain length and destination field info) and the object-map RAM read by the renderer.

Parameters:
- COLS, 10, cells per grid row; also the address stride.
- ROWS, 10, grid rows.
- ADDR_W, 7, object-map address width.
- MAX_PUSH, 2, maximum boxes pushed in one move.
- PHASE_MAX, 47, last animation phase value; 6-bit phase field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle move request; sampled only in IDLE
- dir  in  2  bit1=1 vertical (row), bit0=1 positive step
- player_row  in  7  cowboy row at start
- player_col  in  7  cowboy col at start
- player_on_target  in  1  cowboy's current cell is a target
- n_boxes  in  $clog2(MAX_PUSH+1)  boxes in chain
- dest_target  in  MAX_PUSH+1  bit k=1: cell c(k+1) is a target
- frame_tick  in  1  renderer frame strobe
- wr_addr  out  ADDR_W  object-map write address
- wr_data  out  11  {type[2:0], phase[5:0], dir[1:0]}
- wr_en  out  1  write strobe
- player_row_out  out  7  cowboy row after last completed move
- player_col_out  out  7  cowboy col after last completed move
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at move completion
- err  out  1  one-cycle pulse on rejected request

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all outputs 0; FSM to IDLE; pending-tick flag cleared. A move interrupted by reset is abandoned with the map possibly partial; no further writes.
- Cells: c0 is the cowboy; c1..cn are boxes (n = n_boxes); c(n+1) is the last box's destination. ci = start position + i·step. Address = row·COLS + col, truncated to ADDR_W.
- Type codes: 0 floor, 1 target, 4 cowboy/floor, 7 cowboy/target, 5 box/floor, 6 box/target.
- IDLE:
  - start and n_boxes ≤ MAX_PUSH and c(n+1) inside grid (0..ROWS-1, 0..COLS-1, no underflow wrap) → LOAD.
  - Otherwise start → err pulse next cycle, no write, stays IDLE.
  - start in any other state is ignored.
- LOAD (1 cycle): latch all inputs; phase := 0; busy := 1.
- ANIM:
  - Writes one cell per cycle, c0..cn, data {current type, phase, dir}, wr_en=1.
  - Then → WAIT with wr_en=0.
- WAIT:
  - On frame_tick, or a pending tick: if phase < PHASE_MAX, phase+1 → ANIM; else → COMMIT.
  - A frame_tick during ANIM sets a one-deep pending flag; further ticks are dropped.
- COMMIT: writes, one per cycle, in order c(n+1) down to c0 (phase 0, dir 0):
  - c(k) for k≥2: 6 if dest_target[k-1] else 5.
  - c1: 7 if dest_target[0] else 4.
  - c0: 1 if player_on_target else 0.
- DONE (1 cycle): wr_en=0; done=1; busy=0; player_row_out/col_out := c1; → IDLE.
- Latency (animated): 1 + (PHASE_MAX+1)·(n+1) write cycles + frame waits + (n+2) + 1.
- n_boxes=0: c1 is the cowboy destination; no box writes.

Optional Feature:
- MOVER_ANIM_EN
  - Defined: ANIM/WAIT behaviour as above.
  - Undefined: LOAD goes directly to COMMIT; frame_tick is ignored; latency is 1 + (n+2) + 1 cycles; no phase writes are issued.

Test Plan:
- Default params, animated; start, dir=2'b11, player (3,4), n_boxes=0, dest_target=0, tick every 20 cycles:
  - 48 writes to addr 34, phases 0..47, type 4.
  - Then addr 44←4, addr 34←0.
  - done; player_row_out=4.
- Push 2 boxes, dir=2'b01, player (5,2), dest_target=3'b100:
  - Commit order: addr 55←6, 54←5, 53←4, 52←0.
  - busy low after done.
- Out-of-grid: player (0,9), dir=2'b01, n_boxes=0:
  - err pulse; wr_en never asserted; busy stays 0.
- Reject by chain length: n_boxes=3 with MAX_PUSH=2 → err; no writes.
- Tick during ANIM: frame_tick asserted during the c0 write:
  - Next ANIM pass starts immediately after WAIT entry.
  - Second tick in the same ANIM pass is dropped.
- Reset mid-move: rst_n low during phase 10 → all outputs 0 asynchronously; no writes after release until a new start.
